// File: rtl/interval_timer_ctrl.sv
// Interval-timer controller: prescaled up-counter with start/pause/stop
// sequencing, one-shot or periodic mode and a 1-cycle terminal-count pulse.
module interval_timer_ctrl #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] presc,
  input  logic               periodic,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   period_q, period_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] div_q, div_d;
  logic               periodic_q, periodic_d;
  logic               tc_q, tc_d;
  logic               running;
  logic               step;
  logic               at_top;

  // Dropping pause in PAUSED counts on that same edge, so a pause
  // held for N cycles delays the timeline by exactly N clocks.
  assign running = (state_q == RUN) || (state_q == PAUSED);
  assign step    = running && !pause && (presc_q == div_q);
  assign at_top  = (count_q == period_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    presc_d    = presc_q;
    div_d      = div_q;
    periodic_d = periodic_q;
    tc_d       = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (start && !running) begin
      state_d    = RUN;
      period_d   = period;
      div_d      = presc;
      periodic_d = periodic;
      count_d    = '0;
      presc_d    = '0;
    end else if (running) begin
      if (pause) begin
        state_d = PAUSED;
      end else begin
        state_d = RUN;
        if (step) begin
          presc_d = '0;
          if (!at_top) begin
            count_d = count_q + 1'b1;
          end else begin
            tc_d = 1'b1;
            if (periodic_q) begin
              count_d = '0;
            end else begin
              state_d = DONE;
            end
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      presc_q    <= '0;
      div_q      <= '0;
      periodic_q <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      presc_q    <= presc_d;
      div_q      <= div_d;
      periodic_q <= periodic_d;
      tc_q       <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = running;
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl: directed scenarios plus random commands
// against a tick-counting reference model.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic [7:0] period;
  logic [3:0] presc;
  logic       periodic;
  logic [7:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // model: 0 idle, 1 active (run/paused), 2 done
  int m_state = 0;
  int m_p = 0;
  int m_d = 0;
  int m_per = 0;
  int m_ticks = 0;
  int m_tc = 0;

  always #5 clk = ~clk;

  interval_timer_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pause(pause), .period(period), .presc(presc),
    .periodic(periodic), .count(count), .tc(tc),
    .busy(busy), .done(done)
  );

  // Active ticks since start; a step happens every D+1 ticks and the
  // k-th step leaves count = k mod (P+1), firing tc when that wraps.
  task automatic model_edge();
    int k;
    m_tc = 0;
    if (rst) begin
      m_state = 0; m_ticks = 0;
      m_p = 0; m_d = 0; m_per = 0;
    end else if (stop) begin
      m_state = 0; m_ticks = 0;
    end else if (start && m_state != 1) begin
      m_state = 1; m_ticks = 0;
      m_p = period; m_d = presc; m_per = periodic;
    end else if (m_state == 1 && !pause) begin
      m_ticks++;
      if (m_ticks % (m_d + 1) == 0) begin
        k = m_ticks / (m_d + 1);
        if (k % (m_p + 1) == 0) m_tc = 1;
        if (!m_per && k == m_p + 1) m_state = 2;
      end
    end
  endtask

  function automatic int exp_count();
    if (m_state == 0) return 0;
    if (m_state == 2) return m_p;
    return (m_ticks / (m_d + 1)) % (m_p + 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t",
             tag, obs, expv, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", {24'd0, count}, exp_count());
    chk("tc", {31'd0, tc}, m_tc);
    chk("busy", {31'd0, busy}, (m_state == 1) ? 1 : 0);
    chk("done", {31'd0, done}, (m_state == 2) ? 1 : 0);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_start(int p, int d, int per);
    start = 1'b1; period = p[7:0];
    presc = d[3:0]; periodic = per[0];
    cyc();
    start = 1'b0;
    period = 8'($urandom);
    presc = 4'($urandom);
    periodic = 1'($urandom);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    period = 8'd0; presc = 4'd0; periodic = 1'b0;
    #1;
    run(2);
    chk("rst_count", {24'd0, count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    run(2);

    // periodic P=3 D=0
    do_start(3, 0, 1);
    run(12);

    // one-shot P=2 D=1
    do_stop();
    do_start(2, 1, 0);
    run(10);
    chk("oneshot_done", {31'd0, done}, 1);
    chk("oneshot_hold", {24'd0, count}, 2);

    // pause 5 cycles at count=2
    do_start(5, 0, 1);
    run(2);
    chk("pre_pause", {24'd0, count}, 2);
    pause = 1'b1;
    run(5);
    chk("paused_frozen", {24'd0, count}, 2);
    pause = 1'b0;
    run(12);

    // start while running is ignored
    do_start(1, 3, 0);
    run(10);

    // stop and start together
    stop = 1'b1; start = 1'b1;
    period = 8'd4; periodic = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    chk("stop_start_busy", {31'd0, busy}, 0);
    chk("stop_start_count", {24'd0, count}, 0);
    run(3);

    // full-range period
    do_start(255, 0, 1);
    run(600);

    // P=0: tc every cycle
    do_stop();
    do_start(0, 0, 1);
    run(10);
    chk("p0_tc", {31'd0, tc}, 1);

    // reset mid-run
    do_stop();
    do_start(10, 2, 1);
    run(7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_count", {24'd0, count}, 0);
    run(3);

    // random command mix
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      period = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                           : 8'($urandom_range(0, 6));
      presc = 4'($urandom_range(0, 3));
      periodic = 1'($urandom);
      cyc();
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0; pause = 1'b0;
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
